// File: rtl/truth_table_sweeper_pkg.sv
// Purpose: shared FSM encodings and helpers for the truth-table sweeper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package truth_table_sweeper_pkg;

    // Fixed encodings so that state dumps read the same across builds.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } tts_state_t;

    localparam int TIMER_W = 4;

    // The timer counts SETTLE-1 down to zero, so WAIT lasts SETTLE cycles.
    // SETTLE==0 skips WAIT entirely, so the load value is irrelevant there.
    function automatic logic [TIMER_W-1:0] settle_load(input int settle);
        if (settle == 0) begin
            return '0;
        end
        return TIMER_W'(settle - 1);
    endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Purpose: 4-bit load/count-down timer with a zero flag, paces the WAIT state.
// Latency: load takes effect on the next edge; o_zero is combinational from the count.
// Backpressure: none; counting stops at zero until reloaded.
//  Ports: i_clk, i_reset (sync, active-high), i_load/i_load_val (load count),
//         i_en (decrement when nonzero), o_zero (count == 0).
module settle_timer
    import truth_table_sweeper_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_load_val,
    input  logic               i_en,
    output logic               o_zero
);

    logic [TIMER_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - TIMER_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Purpose: sweeps all 2^N_IN input vectors, compares two boolean implementations per row.
// Latency: SETTLE+1 cycles per row; done 2^N_IN*(SETTLE+1) cycles after busy rises.
// Backpressure: none; start is ignored while busy, abort cancels at any time.
//  Ports: i_clk, i_reset (sync, active-high), i_start, i_abort, o_vec (drive to both
//         functions), i_f_a/i_f_b (their outputs), o_busy, o_done, o_match,
//         o_mismatch_cnt, o_first_bad/_vld, o_row_vld/o_row_idx/o_row_a/o_row_b (per-row trace).
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic            i_abort,
    output logic [N_IN-1:0] o_vec,
    input  logic            i_f_a,
    input  logic            i_f_b,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_match,
    output logic [N_IN:0]   o_mismatch_cnt,
    output logic [N_IN-1:0] o_first_bad,
    output logic            o_first_bad_vld,
    output logic            o_row_vld,
    output logic [N_IN-1:0] o_row_idx,
    output logic            o_row_a,
    output logic            o_row_b
);

    localparam logic [N_IN-1:0]    VEC_LAST   = {N_IN{1'b1}};
    localparam logic [N_IN-1:0]    VEC_ONE    = N_IN'(1);
    localparam logic [N_IN:0]      CNT_ONE    = (N_IN + 1)'(1);
    localparam logic [TIMER_W-1:0] TIMER_LOAD = settle_load(SETTLE);
    // With no settle time every row is a single SAMPLE cycle.
    localparam tts_state_t         ST_ROW     = (SETTLE == 0) ? ST_SAMPLE : ST_WAIT;

    tts_state_t r_state;
    tts_state_t w_state_nxt;

    logic            w_clear;
    logic            w_sample;
    logic            w_timer_load;
    logic            w_timer_en;
    logic            w_timer_zero;
    logic            w_last_row;
    logic            w_mismatch;

    logic [N_IN-1:0] r_vec;
    logic [N_IN:0]   r_mismatch_cnt;
    logic [N_IN-1:0] r_first_bad;
    logic            r_first_bad_vld;
    logic            r_row_vld;
    logic [N_IN-1:0] r_row_idx;
    logic            r_row_a;
    logic            r_row_b;

    assign w_last_row = (r_vec == VEC_LAST);
    assign w_mismatch = (i_f_a != i_f_b);

    settle_timer u_settle_timer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_timer_load),
        .i_load_val (TIMER_LOAD),
        .i_en       (w_timer_en),
        .o_zero     (w_timer_zero)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Abort is checked before the state decode so it beats start and the
    // final SAMPLE alike.
    always_comb begin
        w_state_nxt  = r_state;
        w_clear      = 1'b0;
        w_sample     = 1'b0;
        w_timer_load = 1'b0;
        w_timer_en   = 1'b0;
        if (i_abort) begin
            w_state_nxt = ST_IDLE;
            w_clear     = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        w_clear      = 1'b1;
                        w_timer_load = 1'b1;
                        w_state_nxt  = ST_ROW;
                    end
                end
                ST_WAIT: begin
                    w_timer_en = 1'b1;
                    if (w_timer_zero) begin
                        w_state_nxt = ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    w_sample = 1'b1;
                    if (w_last_row) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_timer_load = 1'b1;
                        w_state_nxt  = ST_ROW;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_vec           <= '0;
            r_mismatch_cnt  <= '0;
            r_first_bad     <= '0;
            r_first_bad_vld <= 1'b0;
            r_row_vld       <= 1'b0;
            r_row_idx       <= '0;
            r_row_a         <= 1'b0;
            r_row_b         <= 1'b0;
        end else begin
            r_row_vld <= 1'b0;
            if (w_clear) begin
                r_vec           <= '0;
                r_mismatch_cnt  <= '0;
                r_first_bad     <= '0;
                r_first_bad_vld <= 1'b0;
            end else if (w_sample) begin
                r_row_vld <= 1'b1;
                r_row_idx <= r_vec;
                r_row_a   <= i_f_a;
                r_row_b   <= i_f_b;
                if (w_mismatch) begin
                    r_mismatch_cnt <= r_mismatch_cnt + CNT_ONE;
                    if (!r_first_bad_vld) begin
                        r_first_bad     <= r_vec;
                        r_first_bad_vld <= 1'b1;
                    end
                end
                // The last row ends the sweep, so vec never wraps.
                if (!w_last_row) begin
                    r_vec <= r_vec + VEC_ONE;
                end
            end
        end
    end

    assign o_vec           = r_vec;
    assign o_busy          = (r_state == ST_WAIT) || (r_state == ST_SAMPLE);
    assign o_done          = (r_state == ST_DONE);
    assign o_match         = (r_state == ST_DONE) && (r_mismatch_cnt == '0);
    assign o_mismatch_cnt  = r_mismatch_cnt;
    assign o_first_bad     = r_first_bad;
    assign o_first_bad_vld = r_first_bad_vld;
    assign o_row_vld       = r_row_vld;
    assign o_row_idx       = r_row_idx;
    assign o_row_a         = r_row_a;
    assign o_row_b         = r_row_b;

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] vec;
    logic       f_a, f_b;
    logic       busy, done, match;
    logic [3:0] mismatch_cnt;
    logic [2:0] first_bad;
    logic       first_bad_vld;
    logic       row_vld;
    logic [2:0] row_idx;
    logic       row_a, row_b;

    int cur_mode = 0;
    int checks = 0;
    int errors = 0;

    // f_a = ~(~a | b&c) with vec = {a,b,c}
    function automatic logic model_fa(input logic [2:0] v);
        return v[2] & ~(v[1] & v[0]);
    endfunction

    function automatic logic model_fb(input int m, input logic [2:0] v);
        case (m)
            1:       return model_fa(v) ^ (v == 3'd5);
            2:       return ~model_fa(v);
            3:       return model_fa(v) ^ ((v == 3'd0) || (v == 3'd7));
            4:       return model_fa(v) ^ (v == 3'd7);
            default: return model_fa(v);
        endcase
    endfunction

    assign f_a = model_fa(vec);
    assign f_b = model_fb(cur_mode, vec);

    truth_table_sweeper #(.N_IN(3), .SETTLE(1)) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_abort(abort),
        .o_vec(vec), .i_f_a(f_a), .i_f_b(f_b),
        .o_busy(busy), .o_done(done), .o_match(match),
        .o_mismatch_cnt(mismatch_cnt), .o_first_bad(first_bad),
        .o_first_bad_vld(first_bad_vld), .o_row_vld(row_vld),
        .o_row_idx(row_idx), .o_row_a(row_a), .o_row_b(row_b)
    );

    // Second build: N_IN=4, SETTLE=0, f_a = f_b = ^vec
    logic       start4 = 1'b0;
    logic       abort4 = 1'b0;
    logic [3:0] vec4;
    logic       f4;
    logic       busy4, done4, match4;
    logic [4:0] cnt4;
    logic [3:0] fb4;
    logic       fbv4, row_vld4;
    logic [3:0] row_idx4;
    logic       row_a4, row_b4;

    assign f4 = ^vec4;

    truth_table_sweeper #(.N_IN(4), .SETTLE(0)) dut4 (
        .i_clk(clk), .i_reset(reset), .i_start(start4), .i_abort(abort4),
        .o_vec(vec4), .i_f_a(f4), .i_f_b(f4),
        .o_busy(busy4), .o_done(done4), .o_match(match4),
        .o_mismatch_cnt(cnt4), .o_first_bad(fb4),
        .o_first_bad_vld(fbv4), .o_row_vld(row_vld4),
        .o_row_idx(row_idx4), .o_row_a(row_a4), .o_row_b(row_b4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vec"},  32'(vec), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_match"}, 32'(match), 0);
        chk({tag, "_cnt"},  32'(mismatch_cnt), 0);
        chk({tag, "_fb"},   32'(first_bad), 0);
        chk({tag, "_fbv"},  32'(first_bad_vld), 0);
        chk({tag, "_rvld"}, 32'(row_vld), 0);
        chk({tag, "_ridx"}, 32'(row_idx), 0);
        chk({tag, "_ra"},   32'(row_a), 0);
        chk({tag, "_rb"},   32'(row_b), 0);
    endtask

    // Runs one sweep on the 3-input DUT. Checks every row trace against the model.
    // Returns with outputs observed #1 after the edge where done rose, or after abort took effect.
    task automatic run_sweep(input int m, input bit restart_mid, input bit abort_last,
                             output int nrows, output int cyc);
        int  c6;
        bit  finished;
        cur_mode = m;
        nrows    = 0;
        cyc      = 0;
        c6       = -10;
        finished = 1'b0;
        @(posedge clk) #1 start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        chk("busy_rise", 32'(busy), 1);
        chk("done_clr_on_start", 32'(done), 0);
        chk("cnt_clr_on_start", 32'(mismatch_cnt), 0);
        chk("fbv_clr_on_start", 32'(first_bad_vld), 0);
        for (int t = 0; t < 200; t++) begin
            @(posedge clk) #1;
            start = 1'b0;
            cyc++;
            if (row_vld) begin
                chk("row_idx_seq", 32'(row_idx), 32'(nrows));
                chk("row_a", 32'(row_a), 32'(model_fa(3'(nrows))));
                chk("row_b", 32'(row_b), 32'(model_fb(m, 3'(nrows))));
                if (nrows == 6) c6 = cyc;
                if (restart_mid && nrows == 2) start = 1'b1;
                nrows++;
            end
            if (done) begin
                finished = 1'b1;
                break;
            end
            if (abort_last && cyc == c6 + 1) begin
                // Now in the SAMPLE cycle of the last row.
                abort = 1'b1;
                @(posedge clk) #1;
                abort = 1'b0;
                cyc++;
                finished = 1'b1;
                break;
            end
        end
        if (!finished) chk("sweep_timeout", 0, 1);
    endtask

    typedef struct {
        int mode;
        int exp_cnt;
        int exp_fb;
        int exp_fbv;
        int exp_match;
    } vec_t;

    vec_t tbl[6];
    int   nrows, cyc;

    initial begin
        tbl[0] = '{0, 0, 0, 0, 1};
        tbl[1] = '{1, 1, 5, 1, 0};
        tbl[2] = '{2, 8, 0, 1, 0};
        tbl[3] = '{2, 8, 0, 1, 0};
        tbl[4] = '{3, 2, 0, 1, 0};
        tbl[5] = '{4, 1, 7, 1, 0};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk_all_zero("reset");
        chk("reset_busy4", 32'(busy4), 0);
        chk("reset_done4", 32'(done4), 0);

        for (int i = 0; i < 6; i++) begin
            run_sweep(tbl[i].mode, 1'b0, 1'b0, nrows, cyc);
            chk("rows", 32'(nrows), 8);
            chk("done_latency", 32'(cyc), 16);
            chk("done", 32'(done), 1);
            chk("busy_at_done", 32'(busy), 0);
            chk("last_rvld_with_done", 32'(row_vld), 1);
            chk("last_ridx", 32'(row_idx), 7);
            chk("vec_hold", 32'(vec), 7);
            chk("mismatch_cnt", 32'(mismatch_cnt), 32'(tbl[i].exp_cnt));
            chk("first_bad", 32'(first_bad), 32'(tbl[i].exp_fb));
            chk("first_bad_vld", 32'(first_bad_vld), 32'(tbl[i].exp_fbv));
            chk("match", 32'(match), 32'(tbl[i].exp_match));
            @(posedge clk) #1;
            chk("done_held", 32'(done), 1);
            chk("rvld_pulse", 32'(row_vld), 0);
            chk("cnt_frozen", 32'(mismatch_cnt), 32'(tbl[i].exp_cnt));
        end

        // Reset in the middle of a sweep with mismatches already counted.
        cur_mode = 2;
        @(posedge clk) #1 start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        begin
            bit seen = 1'b0;
            for (int t = 0; t < 100; t++) begin
                @(posedge clk) #1;
                if (row_vld && row_idx == 3'd3) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("reach_row3", 32'(seen), 1);
        end
        chk("cnt_before_reset", 32'(mismatch_cnt), 4);
        reset = 1'b1;
        @(posedge clk) #1;
        chk_all_zero("midreset");
        reset = 1'b0;
        run_sweep(0, 1'b0, 1'b0, nrows, cyc);
        chk("post_reset_rows", 32'(nrows), 8);
        chk("post_reset_latency", 32'(cyc), 16);
        chk("post_reset_match", 32'(match), 1);
        chk("post_reset_cnt", 32'(mismatch_cnt), 0);
        chk("post_reset_fbv", 32'(first_bad_vld), 0);

        // Start re-pulsed mid-sweep, then abort on the last SAMPLE.
        run_sweep(0, 1'b1, 1'b1, nrows, cyc);
        chk("abort_rows", 32'(nrows), 7);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_no_last_rvld", 32'(row_vld), 0);
        chk("abort_vec", 32'(vec), 0);
        chk("abort_cnt", 32'(mismatch_cnt), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_idle_done", 32'(done), 0);
        chk("abort_idle_busy", 32'(busy), 0);
        chk("abort_idle_rvld", 32'(row_vld), 0);

        // N_IN=4, SETTLE=0 build.
        @(posedge clk) #1 start4 = 1'b1;
        @(posedge clk) #1 start4 = 1'b0;
        chk("b4_busy_rise", 32'(busy4), 1);
        begin
            int  n4 = 0;
            int  c4 = 0;
            bit  fin = 1'b0;
            for (int t = 0; t < 100; t++) begin
                @(posedge clk) #1;
                c4++;
                if (row_vld4) begin
                    chk("b4_row_idx", 32'(row_idx4), 32'(n4));
                    n4++;
                end
                if (done4) begin
                    fin = 1'b1;
                    break;
                end
            end
            chk("b4_finished", 32'(fin), 1);
            chk("b4_rows", 32'(n4), 16);
            chk("b4_latency", 32'(c4), 16);
            chk("b4_match", 32'(match4), 1);
            chk("b4_cnt", 32'(cnt4), 0);
            chk("b4_fbv", 32'(fbv4), 0);
            chk("b4_vec_hold", 32'(vec4), 15);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
